// File: rtl/sti_pkg.sv
// Shared types and constants for the binary-image frame packer.
// Image geometry is fixed at 128 x 128; one memory word holds 16 pixels.
// STI_BORDER_CLR_EN (optional) is consumed by sti_frame_packer through is_border().
package sti_pkg;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 10;

  localparam logic [7:0] THRESH_DEF = 8'd128;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE,
    WAIT_DT
  } sti_state_e;

  typedef struct packed {
    logic [6:0] row;
    logic [6:0] col;
  } pix_pos_t;

  // True for pixels on the outer frame edge, which the DT core needs as background.
  function automatic logic is_border(input pix_pos_t p);
    return (p.row == 7'd0) || (p.row == 7'(IMG_H - 1)) ||
           (p.col == 7'd0) || (p.col == 7'(IMG_W - 1));
  endfunction

endpackage

// File: rtl/sti_word_packer.sv
// Purpose: 16-bit shift register that collects binarised pixels into one memory word.
// Latency: word_vld pulses 1 cycle after the 16th shift; word_dat holds the full word then.
// Backpressure: none; it shifts whenever told to and never stalls the caller.
module sti_word_packer
  import sti_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              shift_en,
  input  logic              clear,
  output logic [WORD_W-1:0] word_dat,
  output logic              word_vld
);

  logic [3:0] bit_cnt;

  // Shift in new bits MSB-first; clear restarts the fill count so a partial word is never flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= 4'd0;
      word_dat <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= shift_en && !clear && (bit_cnt == 4'd15);
      if (shift_en) begin
        word_dat <= {word_dat[WORD_W-2:0], bit_in};
        bit_cnt  <= clear ? 4'd1 : bit_cnt + 4'd1;
      end else if (clear) begin
        bit_cnt  <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/sti_frame_packer.sv
// Purpose: binarise a 128x128 grey raster, pack 16 px/word into the DT image memory, start the DT core.
// Latency: each word is written 1 cycle after its 16th pixel; dt_start 1 cycle after the last write.
// Backpressure: pix_ready drops after the last pixel and stays low until dt_done. Option: STI_BORDER_CLR_EN.
module sti_frame_packer
  import sti_pkg::*;
#(
  parameter logic [7:0] THRESH = THRESH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [7:0]        pix_data,
  input  logic              pix_sof,
  input  logic              pix_eol,
  output logic              sti_wr,
  output logic [ADDR_W-1:0] sti_addr,
  output logic [WORD_W-1:0] sti_do,
  output logic              dt_start,
  input  logic              dt_done,
  output logic              err_sync,
  output logic [14:0]       fg_count
);

  sti_state_e state, nxt;
  pix_pos_t   pos, cur;
  logic [14:0] fg_acc;
  logic        eof_q;
  logic        accept, sof_take, fill_acc, col_last;
  logic        sof_err, eol_err, last_px, drop_partial;
  logic        px_bit, shift_en, clear, word_end;

  assign accept   = pix_valid && pix_ready;
  assign sof_take = accept && pix_sof;
  assign fill_acc = accept && (state == FILL) && !pix_sof;
  // A sof pixel is always position (0,0), whatever the counter says.
  assign cur      = sof_take ? '0 : pos;
  assign col_last = (cur.col == 7'(IMG_W - 1));

  assign sof_err  = sof_take && (state == FILL) && (pos != '0);
  assign eol_err  = fill_acc && (pix_eol != col_last);
  assign last_px  = fill_acc && col_last && (cur.row == 7'(IMG_H - 1));
  // An early eol truncates the current word; its bits are discarded rather than written.
  assign drop_partial = eol_err && (cur.col[3:0] != 4'hF);

  assign shift_en = (sof_take || fill_acc) && !drop_partial;
  assign clear    = sof_take || drop_partial;
  assign word_end = shift_en && (cur.col[3:0] == 4'hF);

  // Threshold the pixel, optionally forcing the frame border to background.
  always_comb begin
    px_bit = (pix_data >= THRESH);
`ifdef STI_BORDER_CLR_EN
    if (is_border(cur)) px_bit = 1'b0;
`endif
  end

  sti_word_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .bit_in   (px_bit),
    .shift_en (shift_en),
    .clear    (clear),
    .word_dat (sti_do),
    .word_vld (sti_wr)
  );

  // Next-state and Moore outputs of the frame FSM.
  always_comb begin
    nxt      = state;
    dt_start = 1'b0;
    case (state)
      IDLE:    if (sof_take) nxt = FILL;
      FILL:    if (eof_q) nxt = DONE;
      DONE: begin
        dt_start = 1'b1;
        nxt      = WAIT_DT;
      end
      WAIT_DT: if (dt_done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register plus registered ready (low from the last pixel until the DT core is done).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pix_ready <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      state     <= nxt;
      pix_ready <= (nxt == IDLE) || ((nxt == FILL) && !last_px);
      eof_q     <= last_px;
    end
  end

  // Raster position counter; advances only on accepted pixels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos <= '0;
    end else if (sof_take) begin
      pos.row <= 7'd0;
      pos.col <= 7'd1;
    end else if (fill_acc) begin
      if (col_last || pix_eol) begin
        pos.col <= 7'd0;
        pos.row <= pos.row + 7'd1;
      end else begin
        pos.col <= pos.col + 7'd1;
      end
    end
  end

  // Word address for the pending write, plus the framing-error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sti_addr <= '0;
      err_sync <= 1'b0;
    end else begin
      err_sync <= sof_err || eol_err;
      if (word_end) sti_addr <= {cur.row, cur.col[6:4]};
    end
  end

  // Object-pixel accumulator; published only when the frame completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fg_acc   <= '0;
      fg_count <= '0;
    end else begin
      if (sof_take)      fg_acc <= {14'd0, px_bit};
      else if (fill_acc) fg_acc <= fg_acc + {14'd0, px_bit};
      if ((state == FILL) && eof_q) fg_count <= fg_acc;
    end
  end

endmodule

// File: tb/tb_sti_frame_packer.sv
// Scoreboard bench for sti_frame_packer: stimulus pushes expected {addr,word} writes,
// a negedge monitor pops and compares each sti_wr. Expected values follow STI_BORDER_CLR_EN.
module tb_sti_frame_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pix_valid, pix_ready, pix_sof, pix_eol;
  logic [7:0]  pix_data;
  logic        sti_wr, dt_start, dt_done, err_sync;
  logic [9:0]  sti_addr;
  logic [15:0] sti_do;
  logic [14:0] fg_count;

`ifdef STI_BORDER_CLR_EN
  localparam int FG_RAMP = 7938;  // rows 1..126, cols 64..126
  localparam int FG_SYNC = 101;   // row 3 cols 1..100, plus (4,1)
`else
  localparam int FG_RAMP = 8192;  // all rows, cols 64..127
  localparam int FG_SYNC = 104;   // sof pixel, (0,17), row 3 cols 0..100, (4,1)
`endif

  int checks = 0, errors = 0;
  int cyc = 0, dt_cnt = 0, err_cnt = 0, wr_cnt = 0, wr1023_cyc = -100;
  logic [25:0] exp_q[$];

  sti_frame_packer dut (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eol(pix_eol),
    .sti_wr(sti_wr), .sti_addr(sti_addr), .sti_do(sti_do),
    .dt_start(dt_start), .dt_done(dt_done), .err_sync(err_sync), .fg_count(fg_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every memory write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (reset) begin
      if (sti_wr) begin
        logic [25:0] e;
        wr_cnt++;
        if (sti_addr == 10'd1023) wr1023_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr=%0d data=%h, none expected", sti_addr, sti_do);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if ({sti_addr, sti_do} !== e) begin
            errors++;
            $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                     sti_addr, sti_do, e[25:16], e[15:0]);
          end
        end
      end
      if (dt_start) dt_cnt++;
      if (err_sync) err_cnt++;
    end
  end

  function automatic logic [15:0] mask_for(input int a);
    logic [15:0] m = 16'hFFFF;
`ifdef STI_BORDER_CLR_EN
    int r = a / 8;
    int w = a % 8;
    if (r == 0 || r == 127) m = 16'h0000;
    else begin
      if (w == 0) m[15] = 1'b0;
      if (w == 7) m[0] = 1'b0;
    end
`endif
    return m;
  endfunction

  task automatic expect_range(input int a0, input int a1, input logic [15:0] pat);
    for (int a = a0; a <= a1; a++) exp_q.push_back({10'(a), pat & mask_for(a)});
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send(input logic [7:0] d, input logic s, input logic e);
    int n = 0;
    pix_valid = 1'b1; pix_data = d; pix_sof = s; pix_eol = e;
    while (!pix_ready && n < 100) begin @(negedge clk); n++; end
    if (!pix_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: pix_ready=0 for %0d cycles, required 1", n);
    end else begin
      @(negedge clk);
    end
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
  endtask

  task automatic send_run(input int row, input int c0, input int c1, input int data,
                          input bit ramp, input bit sof, input bit eol);
    for (int c = c0; c <= c1; c++)
      send(ramp ? 8'(c * 2) : 8'(data), sof && (c == c0), eol && (c == c1));
  endtask

  task automatic send_rows(input int r0, input int r1, input int data, input bit ramp,
                           input bit sof_first);
    for (int r = r0; r <= r1; r++) send_run(r, 0, 127, data, ramp, sof_first && (r == r0), 1'b1);
  endtask

  // mode 0: plain handshake; 1: dt_done pulsed during dt_start; 2: hold pix_valid (backpressure).
  task automatic finish_frame(input int exp_fg, input int mode);
    int n = 0, bad = 0, w0, e0, d0;
    while (!dt_start && n < 64) begin @(negedge clk); n++; end
    if (!dt_start) begin
      checks++; errors++;
      $display("FAIL dt_start_timeout: dt_start=0 after %0d cycles, required 1", n);
      return;
    end
    check("dt_start_after_last_write", cyc - wr1023_cyc, 1);
    check("ready_low_in_done", pix_ready, 0);
    if (mode == 1) begin
      dt_done = 1'b1; @(negedge clk); dt_done = 1'b0;
      repeat (3) begin @(negedge clk); if (pix_ready) bad++; end
      check("early_dt_done_ignored", bad, 0);
    end else if (mode == 2) begin
      pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 8'hFF;
      repeat (10) begin @(negedge clk); if (pix_ready) bad++; end
      check("backpressure_ready_low", bad, 0);
    end else begin
      @(negedge clk);
    end
    check("fg_count", fg_count, exp_fg);
    check("all_writes_seen", exp_q.size(), 0);
    dt_done = 1'b1; @(negedge clk); dt_done = 1'b0;
    check("ready_after_dt_done", pix_ready, 1);
    if (mode == 2) begin
      w0 = wr_cnt; e0 = err_cnt; d0 = dt_cnt;
      repeat (20) @(negedge clk);
      pix_valid = 1'b0;
      @(negedge clk);
      check("idle_drop_no_write", wr_cnt - w0, 0);
      check("idle_drop_no_err", err_cnt - e0, 0);
      check("idle_drop_no_dt_start", dt_cnt - d0, 0);
      check("idle_still_ready", pix_ready, 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_ready"}, pix_ready, 0);
    check({tag, "_sti_wr"}, sti_wr, 0);
    check({tag, "_sti_addr"}, sti_addr, 0);
    check({tag, "_sti_do"}, sti_do, 0);
    check({tag, "_dt_start"}, dt_start, 0);
    check({tag, "_err_sync"}, err_sync, 0);
    check({tag, "_fg_count"}, fg_count, 0);
  endtask

  initial begin
    int e0, d0;
    pix_valid = 1'b0; pix_data = 8'd0; pix_sof = 1'b0; pix_eol = 1'b0; dt_done = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", pix_ready, 1);

    // Ramp frame: pix = col*2 -> right half of every row is object
    for (int a = 0; a < 1024; a++) expect_range(a, a, (a % 8 >= 4) ? 16'hFFFF : 16'h0000);
    send_rows(0, 127, 0, 1'b1, 1'b1);
    finish_frame(FG_RAMP, 2);
    check("ramp_write_count", wr_cnt, 1024);

    // Resync frame: sof at (5,40), early eol at (3,100)
    expect_range(0, 41, 16'hFFFF);
    expect_range(0, 0, 16'h8000);
    expect_range(1, 1, 16'h4000);
    expect_range(2, 23, 16'h0000);
    expect_range(24, 29, 16'hFFFF);
    expect_range(32, 32, 16'h4000);
    expect_range(33, 1023, 16'h0000);
    send_rows(0, 4, 255, 1'b0, 1'b1);
    send_run(5, 0, 39, 255, 1'b0, 1'b0, 1'b0);
    e0 = err_cnt;
    send(8'd200, 1'b1, 1'b0);
    send_run(0, 1, 16, 0, 1'b0, 1'b0, 1'b0);
    send(8'd255, 1'b0, 1'b0);
    send_run(0, 18, 127, 0, 1'b0, 1'b0, 1'b1);
    check("sof_resync_err_pulses", err_cnt - e0, 1);
    send_rows(1, 2, 0, 1'b0, 1'b0);
    e0 = err_cnt;
    send_run(3, 0, 100, 255, 1'b0, 1'b0, 1'b1);
    send(8'd0, 1'b0, 1'b0);
    send(8'd255, 1'b0, 1'b0);
    send_run(4, 2, 127, 0, 1'b0, 1'b0, 1'b1);
    check("early_eol_err_pulses", err_cnt - e0, 1);
    send_rows(5, 127, 0, 1'b0, 1'b0);
    finish_frame(FG_SYNC, 1);

    // Reset at pixel 9000, then a clean frame
    expect_range(0, 561, 16'h0000);
    send_rows(0, 69, 0, 1'b0, 1'b1);
    send_run(70, 0, 39, 0, 1'b0, 1'b0, 1'b0);
    check("pre_reset_addr", sti_addr, 561);
    d0 = dt_cnt;
    reset = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    check("midframe_writes_seen", exp_q.size(), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_midframe_reset", pix_ready, 1);
    check("no_dt_start_from_reset", dt_cnt - d0, 0);
    for (int a = 0; a < 1024; a++) expect_range(a, a, (a % 8 >= 4) ? 16'hFFFF : 16'h0000);
    send_rows(0, 127, 0, 1'b1, 1'b1);
    finish_frame(FG_RAMP, 0);
    check("single_dt_start_after_reset", dt_cnt - d0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
